// File: rtl/memory_access_pkg.sv
// rtl/memory_access_pkg.sv - shared state, load/store type encodings and alignment helper
package memory_access_pkg;

  typedef enum logic [1:0] {
    S_IDLE,
    S_REQUEST,
    S_WAIT,
    S_DONE
  } state_e;

  localparam logic [2:0] LOAD_LB  = 3'b000;
  localparam logic [2:0] LOAD_LH  = 3'b001;
  localparam logic [2:0] LOAD_LW  = 3'b010;
  localparam logic [2:0] LOAD_LBU = 3'b100;
  localparam logic [2:0] LOAD_LHU = 3'b101;

  localparam logic [1:0] STORE_SB = 2'b00;
  localparam logic [1:0] STORE_SH = 2'b01;
  localparam logic [1:0] STORE_SW = 2'b10;

  // size: 00 byte, 01 halfword, anything else word
  function automatic logic is_misaligned(input logic [1:0] size, input logic [1:0] offset);
    case (size)
      2'b00:   is_misaligned = 1'b0;
      2'b01:   is_misaligned = offset[0];
      default: is_misaligned = (offset != 2'b00);
    endcase
  endfunction

endpackage

// File: rtl/load_data_aligner.sv
// rtl/load_data_aligner.sv - selects the addressed lane of a bus word and extends it
module load_data_aligner
  import memory_access_pkg::*;
(
  input  logic [31:0] word,
  input  logic [1:0]  offset,
  input  logic [2:0]  load_type,
  output logic [31:0] read_data
);

  logic [31:0] shifted;

  always_comb begin
    shifted = word >> {offset, 3'b000};
    case (load_type)
      LOAD_LB:  read_data = {{24{shifted[7]}}, shifted[7:0]};
      LOAD_LH:  read_data = {{16{shifted[15]}}, shifted[15:0]};
      LOAD_LBU: read_data = {24'h0, shifted[7:0]};
      LOAD_LHU: read_data = {16'h0, shifted[15:0]};
      default:  read_data = word;
    endcase
  end

endmodule

// File: rtl/memory_access_unit.sv
// rtl/memory_access_unit.sv - single-outstanding load/store unit bridging the core to a word bus
module memory_access_unit
  import memory_access_pkg::*;
(
  input  logic        clk,
  input  logic        reset,
  input  logic        memory_enable,
  input  logic        memory_command,
  input  logic [31:0] address,
  input  logic [31:0] write_data,
  input  logic [2:0]  load_type,
  input  logic [1:0]  store_type,
  output logic        memory_ready,
  output logic        memory_valid,
  output logic [31:0] read_data,
  output logic [31:0] read_word,
  output logic        misaligned_exception,
  output logic        access_fault,
  output logic        bus_request,
  output logic        bus_write,
  output logic [31:0] bus_address,
  output logic [3:0]  bus_byte_enable,
  output logic [31:0] bus_write_data,
  input  logic        bus_grant,
  input  logic        bus_response_valid,
  input  logic        bus_error,
  input  logic [31:0] bus_read_data
);

  state_e      state_q, state_d;
  logic        cmd_q, cmd_d;
  logic [31:0] addr_q, addr_d;
  logic [2:0]  load_type_q, load_type_d;
  logic [3:0]  be_q, be_d;
  logic [31:0] wdata_q, wdata_d;
  logic [31:0] read_word_q, read_word_d;
  logic [31:0] read_data_q, read_data_d;
  logic        fault_q, fault_d;

  logic        accept;
  logic        capture;
  logic [31:0] aligned_data;

  load_data_aligner u_aligner (
    .word      (bus_read_data),
    .offset    (addr_q[1:0]),
    .load_type (load_type_q),
    .read_data (aligned_data)
  );

  always_comb begin
    misaligned_exception = is_misaligned(memory_command ? store_type : load_type[1:0],
                                         address[1:0]);
    accept  = (state_q == S_IDLE) && memory_enable && !misaligned_exception;
    // a response only counts once the bus has granted (or grants in the same cycle)
    capture = ((state_q == S_REQUEST) && bus_grant && bus_response_valid) ||
              ((state_q == S_WAIT) && bus_response_valid);

    state_d     = state_q;
    cmd_d       = cmd_q;
    addr_d      = addr_q;
    load_type_d = load_type_q;
    be_d        = be_q;
    wdata_d     = wdata_q;
    read_word_d = read_word_q;
    read_data_d = read_data_q;
    fault_d     = fault_q;

    case (state_q)
      S_IDLE:    if (accept) state_d = S_REQUEST;
      S_REQUEST: if (bus_grant) state_d = bus_response_valid ? S_DONE : S_WAIT;
      S_WAIT:    if (bus_response_valid) state_d = S_DONE;
      default:   state_d = S_IDLE;
    endcase

    if (accept) begin
      cmd_d       = memory_command;
      addr_d      = address;
      load_type_d = load_type;
      be_d        = 4'b1111;
      wdata_d     = write_data;
      if (memory_command) begin
        case (store_type)
          STORE_SB: begin
            be_d    = 4'b0001 << address[1:0];
            wdata_d = {4{write_data[7:0]}};
          end
          STORE_SH: begin
            be_d    = 4'b0011 << {address[1], 1'b0};
            wdata_d = {2{write_data[15:0]}};
          end
          default: ;
        endcase
      end
    end

    if (capture) begin
      read_word_d = bus_read_data;
      read_data_d = aligned_data;
      fault_d     = bus_error;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q     <= S_IDLE;
      cmd_q       <= 1'b0;
      addr_q      <= 32'h0;
      load_type_q <= LOAD_LW;
      be_q        <= 4'h0;
      wdata_q     <= 32'h0;
      read_word_q <= 32'h0;
      read_data_q <= 32'h0;
      fault_q     <= 1'b0;
    end else begin
      state_q     <= state_d;
      cmd_q       <= cmd_d;
      addr_q      <= addr_d;
      load_type_q <= load_type_d;
      be_q        <= be_d;
      wdata_q     <= wdata_d;
      read_word_q <= read_word_d;
      read_data_q <= read_data_d;
      fault_q     <= fault_d;
    end
  end

  // bus command is decoded from state so an asynchronous reset drops it at once
  assign memory_ready    = (state_q == S_IDLE);
  assign memory_valid    = (state_q == S_DONE);
  assign access_fault    = memory_valid && fault_q;
  assign bus_request     = (state_q == S_REQUEST);
  assign bus_write       = bus_request && cmd_q;
  assign bus_byte_enable = bus_request ? be_q : 4'h0;
  assign bus_address     = {addr_q[31:2], 2'b00};
  assign bus_write_data  = wdata_q;
  assign read_word       = read_word_q;
  assign read_data       = read_data_q;

endmodule

// File: tb/tb_memory_access_unit.sv
// tb/tb_memory_access_unit.sv - scoreboard bench for memory_access_unit
module tb_memory_access_unit;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        memory_enable = 1'b0;
  logic        memory_command = 1'b0;
  logic [31:0] address = 32'h0;
  logic [31:0] write_data = 32'h0;
  logic [2:0]  load_type = 3'b010;
  logic [1:0]  store_type = 2'b10;
  logic        memory_ready, memory_valid, misaligned_exception, access_fault;
  logic [31:0] read_data, read_word;
  logic        bus_request, bus_write;
  logic [31:0] bus_address, bus_write_data;
  logic [3:0]  bus_byte_enable;
  logic        bus_grant = 1'b0;
  logic        bus_response_valid = 1'b0;
  logic        bus_error = 1'b0;
  logic [31:0] bus_read_data = 32'h0;

  int total = 0;
  int bad = 0;

  typedef struct {
    logic [31:0] rd;
    logic [31:0] rw;
    logic        fault;
    logic        chk;
  } exp_t;

  exp_t sb_q[$];

  memory_access_unit dut (
    .clk                  (clk),
    .reset                (reset),
    .memory_enable        (memory_enable),
    .memory_command       (memory_command),
    .address              (address),
    .write_data           (write_data),
    .load_type            (load_type),
    .store_type           (store_type),
    .memory_ready         (memory_ready),
    .memory_valid         (memory_valid),
    .read_data            (read_data),
    .read_word            (read_word),
    .misaligned_exception (misaligned_exception),
    .access_fault         (access_fault),
    .bus_request          (bus_request),
    .bus_write            (bus_write),
    .bus_address          (bus_address),
    .bus_byte_enable      (bus_byte_enable),
    .bus_write_data       (bus_write_data),
    .bus_grant            (bus_grant),
    .bus_response_valid   (bus_response_valid),
    .bus_error            (bus_error),
    .bus_read_data        (bus_read_data)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s actual=%h expected=%h", name, act, exp);
    end
  endtask

  always @(negedge clk) begin
    if (memory_valid) begin
      if (sb_q.size() == 0) begin
        chk("unexpected_valid", 32'd1, 32'd0);
      end else begin
        exp_t e;
        e = sb_q.pop_front();
        if (e.chk) begin
          chk("read_data", read_data, e.rd);
          chk("read_word", read_word, e.rw);
        end
        chk("access_fault", {31'h0, access_fault}, {31'h0, e.fault});
      end
    end
  end

  task automatic access(input logic cmd, input logic [31:0] addr, input logic [31:0] wd,
                        input logic [2:0] lt, input logic [1:0] st,
                        input int gdly, input int rdly, input logic stray,
                        input logic [31:0] rdata, input logic err,
                        input logic [31:0] exp_rd, input logic [3:0] exp_be,
                        input logic [31:0] exp_wd);
    int n;
    n = 0;
    while (!memory_ready && n < 20) begin
      @(posedge clk); #1;
      n++;
    end
    if (!memory_ready) chk("ready_timeout", 32'd0, 32'd1);
    memory_enable  = 1'b1;
    memory_command = cmd;
    address        = addr;
    write_data     = wd;
    load_type      = lt;
    store_type     = st;
    sb_q.push_back('{rd: exp_rd, rw: rdata, fault: err, chk: !cmd});
    @(posedge clk); #1;
    memory_enable = 1'b0;
    for (int i = 0; i <= gdly; i++) begin
      bus_grant          = (i == gdly);
      bus_response_valid = ((i == gdly) && (rdly == 0)) || (stray && (i == 0) && (gdly > 0));
      bus_read_data      = (i == gdly) ? rdata : 32'hBAD0BAD0;
      bus_error          = (i == gdly) ? err : 1'b1;
      @(negedge clk);
      chk("bus_request", {31'h0, bus_request}, 32'd1);
      chk("bus_write", {31'h0, bus_write}, {31'h0, cmd});
      chk("bus_address", bus_address, {addr[31:2], 2'b00});
      chk("bus_byte_enable", {28'h0, bus_byte_enable}, {28'h0, exp_be});
      if (cmd) chk("bus_write_data", bus_write_data, exp_wd);
      @(posedge clk); #1;
    end
    bus_grant          = 1'b0;
    bus_response_valid = 1'b0;
    for (int i = 1; i <= rdly; i++) begin
      bus_response_valid = (i == rdly);
      bus_read_data      = (i == rdly) ? rdata : 32'hBAD0BAD0;
      bus_error          = (i == rdly) ? err : 1'b1;
      @(negedge clk);
      chk("wait_no_valid", {31'h0, memory_valid}, 32'd0);
      @(posedge clk); #1;
    end
    bus_response_valid = 1'b0;
    bus_error          = 1'b0;
    @(negedge clk);
    chk("valid_latency", {31'h0, memory_valid}, 32'd1);
    @(posedge clk); #1;
  endtask

  typedef struct {
    logic        cmd;
    logic [1:0]  off;
    logic [2:0]  lt;
    logic [1:0]  st;
    logic        mis;
  } mis_t;

  mis_t mis_tab[9] = '{
    '{1'b0, 2'd3, 3'b000, 2'b00, 1'b0},
    '{1'b0, 2'd1, 3'b001, 2'b00, 1'b1},
    '{1'b0, 2'd2, 3'b001, 2'b00, 1'b0},
    '{1'b0, 2'd2, 3'b010, 2'b00, 1'b1},
    '{1'b0, 2'd3, 3'b101, 2'b10, 1'b1},
    '{1'b1, 2'd1, 3'b010, 2'b00, 1'b0},
    '{1'b1, 2'd3, 3'b000, 2'b01, 1'b1},
    '{1'b1, 2'd0, 3'b010, 2'b10, 1'b0},
    '{1'b1, 2'd2, 3'b000, 2'b10, 1'b1}
  };

  initial begin
    #200000;
    $display("FAIL watchdog actual=timeout expected=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    #12;
    chk("rst_ready", {31'h0, memory_ready}, 32'd1);
    chk("rst_valid", {31'h0, memory_valid}, 32'd0);
    chk("rst_fault", {31'h0, access_fault}, 32'd0);
    chk("rst_bus_request", {31'h0, bus_request}, 32'd0);
    chk("rst_bus_write", {31'h0, bus_write}, 32'd0);
    chk("rst_bus_be", {28'h0, bus_byte_enable}, 32'd0);
    chk("rst_read_data", read_data, 32'h0);
    chk("rst_read_word", read_word, 32'h0);
    @(posedge clk); #1;
    reset = 1'b0;
    @(posedge clk); #1;

    // loads: LW, LB/LBU/LH/LHU lanes
    access(1'b0, 32'h100, 32'h0, 3'b010, 2'b00, 0, 0, 1'b0, 32'hDEADBEEF, 1'b0, 32'hDEADBEEF, 4'hF, 32'h0);
    access(1'b0, 32'h103, 32'h0, 3'b000, 2'b00, 0, 0, 1'b0, 32'h80123456, 1'b0, 32'hFFFFFF80, 4'hF, 32'h0);
    access(1'b0, 32'h103, 32'h0, 3'b100, 2'b00, 0, 0, 1'b0, 32'h80123456, 1'b0, 32'h00000080, 4'hF, 32'h0);
    access(1'b0, 32'h102, 32'h0, 3'b001, 2'b00, 0, 0, 1'b0, 32'h80123456, 1'b0, 32'hFFFF8012, 4'hF, 32'h0);
    access(1'b0, 32'h102, 32'h0, 3'b101, 2'b00, 0, 0, 1'b0, 32'h80123456, 1'b0, 32'h00008012, 4'hF, 32'h0);
    access(1'b0, 32'h100, 32'h0, 3'b000, 2'b00, 0, 1, 1'b0, 32'h80123456, 1'b0, 32'h00000056, 4'hF, 32'h0);

    // stores
    access(1'b1, 32'h202, 32'h0000ABCD, 3'b010, 2'b01, 0, 0, 1'b0, 32'h0, 1'b0, 32'h0, 4'b1100, 32'hABCDABCD);
    access(1'b1, 32'h201, 32'h00000012, 3'b010, 2'b00, 1, 0, 1'b0, 32'h0, 1'b0, 32'h0, 4'b0010, 32'h12121212);
    access(1'b1, 32'h300, 32'hCAFEF00D, 3'b010, 2'b10, 0, 0, 1'b0, 32'h0, 1'b0, 32'h0, 4'b1111, 32'hCAFEF00D);

    // grant delayed 3 cycles with a stray response before grant, then WAIT-state response
    access(1'b0, 32'h104, 32'h0, 3'b010, 2'b00, 3, 0, 1'b1, 32'h11223344, 1'b0, 32'h11223344, 4'hF, 32'h0);
    access(1'b0, 32'h108, 32'h0, 3'b010, 2'b00, 0, 2, 1'b0, 32'h55667788, 1'b0, 32'h55667788, 4'hF, 32'h0);

    // bus error response
    access(1'b0, 32'h10C, 32'h0, 3'b010, 2'b00, 0, 0, 1'b0, 32'hA5A5A5A5, 1'b1, 32'hA5A5A5A5, 4'hF, 32'h0);

    // misaligned LW is dropped
    memory_enable  = 1'b1;
    memory_command = 1'b0;
    address        = 32'h101;
    load_type      = 3'b010;
    @(negedge clk);
    chk("mis_flag", {31'h0, misaligned_exception}, 32'd1);
    @(posedge clk); #1;
    memory_enable = 1'b0;
    @(negedge clk);
    chk("mis_no_request", {31'h0, bus_request}, 32'd0);
    chk("mis_ready", {31'h0, memory_ready}, 32'd1);

    foreach (mis_tab[k]) begin
      memory_command = mis_tab[k].cmd;
      address        = {30'h40, mis_tab[k].off};
      load_type      = mis_tab[k].lt;
      store_type     = mis_tab[k].st;
      #1;
      chk($sformatf("mis_tab%0d", k), {31'h0, misaligned_exception}, {31'h0, mis_tab[k].mis});
    end
    @(posedge clk); #1;

    // reset while REQUEST: bus_request drops before any clock edge
    memory_enable  = 1'b1;
    memory_command = 1'b0;
    address        = 32'h400;
    load_type      = 3'b010;
    @(posedge clk); #1;
    memory_enable = 1'b0;
    chk("pre_rst_request", {31'h0, bus_request}, 32'd1);
    #1 reset = 1'b1;
    #1;
    chk("rst_async_request", {31'h0, bus_request}, 32'd0);
    chk("rst_async_ready", {31'h0, memory_ready}, 32'd1);
    @(posedge clk); #1;
    reset = 1'b0;

    // reset while WAIT: late response afterwards must not complete anything
    memory_enable = 1'b1;
    address       = 32'h404;
    @(posedge clk); #1;
    memory_enable = 1'b0;
    bus_grant     = 1'b1;
    @(posedge clk); #1;
    bus_grant = 1'b0;
    chk("wait_state_busy", {31'h0, memory_ready}, 32'd0);
    #1 reset = 1'b1;
    #1;
    chk("rst_wait_ready", {31'h0, memory_ready}, 32'd1);
    chk("rst_wait_request", {31'h0, bus_request}, 32'd0);
    @(posedge clk); #1;
    reset              = 1'b0;
    bus_response_valid = 1'b1;
    bus_read_data      = 32'h99999999;
    @(posedge clk); #1;
    bus_response_valid = 1'b0;
    @(negedge clk);
    chk("rst_no_valid", {31'h0, memory_valid}, 32'd0);
    chk("rst_idle", {31'h0, memory_ready}, 32'd1);

    repeat (3) @(posedge clk);
    #1;
    chk("sb_drained", sb_q.size(), 32'd0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
